// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the memory port arbiter and the core's memory control unit.
package mem_arb_pkg;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_NPORTS  = 2;
    localparam int DEF_TIMEOUT = 64;
    // Same encoding width as dm_ctl in the core's memory control unit.
    localparam int MEM_CTLW    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Inputs are guaranteed below 2*n, so one subtraction wraps.
    function automatic int wrap_idx(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and backing-memory-side signals of the arbiter, bundled for port connection.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int NPORTS = DEF_NPORTS,
    parameter int CTLW   = MEM_CTLW
);
    logic [NPORTS-1:0]      req;
    logic [NPORTS*XLEN-1:0] addr;
    logic [NPORTS*XLEN-1:0] wdata;
    logic [NPORTS*CTLW-1:0] ctl;
    logic [NPORTS-1:0]      ack;
    logic [XLEN-1:0]        rdata;
    logic                   err;
    logic                   mem_req;
    logic [XLEN-1:0]        mem_addr;
    logic [XLEN-1:0]        mem_wdata;
    logic [CTLW-1:0]        mem_ctl;
    logic [XLEN-1:0]        mem_rdata;
    logic                   mem_ack;

    modport slave (
        input  req, addr, wdata, ctl, mem_rdata, mem_ack,
        output ack, rdata, err, mem_req, mem_addr, mem_wdata, mem_ctl
    );

    modport master (
        output req, addr, wdata, ctl, mem_rdata, mem_ack,
        input  ack, rdata, err, mem_req, mem_addr, mem_wdata, mem_ctl
    );

endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin pick: first requesting port after last_grant, wrapping.
// Zero latency; no flow control of its own.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int  NPORTS = DEF_NPORTS,
    localparam int IDXW   = $clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] req_i,
    input  logic [IDXW-1:0]   last_grant_i,
    output logic [IDXW-1:0]   grant_o,
    output logic              any_req_o
);
    logic [NPORTS-1:0] rot;

    always_comb begin
        rot = '0;
        for (int i = 0; i < NPORTS; i++) begin
            rot[i] = req_i[IDXW'(wrap_idx(int'(last_grant_i) + 1 + i, NPORTS))];
        end
    end

    // Descending scan so the lowest rotated position wins.
    always_comb begin
        grant_o = last_grant_i;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                grant_o = IDXW'(wrap_idx(int'(last_grant_i) + 1 + i, NPORTS));
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter of NPORTS req/ack requesters onto one memory port with bounded wait.
// Best case ack two edges after req is sampled; requesters hold req until ack, memory holds until mem_ack or timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int NPORTS  = DEF_NPORTS,
    parameter int CTLW    = MEM_CTLW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int              IDXW      = $clog2(NPORTS);
    localparam int              CNTW      = $clog2(TIMEOUT);
    localparam logic [CNTW-1:0] LAST_WAIT = CNTW'(TIMEOUT - 1);
    localparam logic [IDXW-1:0] LAST_PORT = IDXW'(NPORTS - 1);

    arb_state_e        state_q, state_d;
    logic [IDXW-1:0]   last_grant_q, last_grant_d;
    logic [IDXW-1:0]   grant_q, grant_d;
    logic [NPORTS-1:0] ack_q, ack_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              mem_req_q, mem_req_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [CTLW-1:0]   mem_ctl_q, mem_ctl_d;
    logic [CNTW-1:0]   wait_cnt_q, wait_cnt_d;

    logic [IDXW-1:0]   pick;
    logic              any_req;
    logic [XLEN-1:0]   sel_addr, sel_wdata;
    logic [CTLW-1:0]   sel_ctl;

    rr_picker #(.NPORTS(NPORTS)) u_picker (
        .req_i        (bus.req),
        .last_grant_i (last_grant_q),
        .grant_o      (pick),
        .any_req_o    (any_req)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_ctl   = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (IDXW'(p) == pick) begin
                sel_addr  = bus.addr[p*XLEN +: XLEN];
                sel_wdata = bus.wdata[p*XLEN +: XLEN];
                sel_ctl   = bus.ctl[p*CTLW +: CTLW];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        ack_d        = '0;
        err_d        = err_q;
        rdata_d      = rdata_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_ctl_d    = mem_ctl_q;
        wait_cnt_d   = wait_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d     = pick;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_ctl_d   = sel_ctl;
                    mem_req_d   = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    rdata_d         = bus.mem_rdata;
                    err_d           = 1'b0;
                    mem_req_d       = 1'b0;
                    ack_d[grant_q]  = 1'b1;
                    state_d         = RESP;
                end else if (wait_cnt_q == LAST_WAIT) begin
                    rdata_d         = '0;
                    err_d           = 1'b1;
                    mem_req_d       = 1'b0;
                    ack_d[grant_q]  = 1'b1;
                    state_d         = RESP;
                end else if (wait_cnt_q != {CNTW{1'b1}}) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            RESP: begin
                // err only accompanies the ack pulse; requesters may still hold req here.
                last_grant_d = grant_q;
                err_d        = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_PORT;
            grant_q      <= '0;
            ack_q        <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_ctl_q    <= '0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_ctl_q    <= mem_ctl_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_ctl   = mem_ctl_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences, randomized run against a transaction model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int XLEN    = 32;
    localparam int NPORTS  = 4;
    localparam int CTLW    = 4;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.XLEN(XLEN), .NPORTS(NPORTS), .CTLW(CTLW)) bus ();

    mem_port_arbiter #(.XLEN(XLEN), .NPORTS(NPORTS), .CTLW(CTLW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Memory responder: acks cur_lat cycles after mem_req is first seen high.
    bit   mem_auto   = 1'b1;
    bit   mem_active = 1'b0;
    int   next_lat   = 0;
    int   cur_lat    = 0;
    int   mem_cnt    = 0;
    logic [NPORTS-1:0] prev_req;

    logic [31:0] p_addr  [NPORTS];
    logic [31:0] p_wdata [NPORTS];
    logic [3:0]  p_ctl   [NPORTS];

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  ctl;
        int          lat;
        logic [3:0]  exp_ack;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_n;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [31:0] rdfn(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E3779B9) ^ 32'h5A5A0001;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        prev_req = bus.req;
        @(posedge clk);
        #1;
        cyc++;
        if (mem_auto) begin
            if (bus.mem_req) begin
                if (!mem_active) begin
                    mem_active = 1'b1;
                    mem_cnt    = 0;
                    cur_lat    = next_lat;
                end
                bus.mem_ack = (mem_cnt == cur_lat);
                mem_cnt++;
            end else begin
                mem_active  = 1'b0;
                bus.mem_ack = 1'b0;
            end
            bus.mem_rdata = bus.mem_ack ? rdfn(bus.mem_addr) : $urandom;
        end
    endtask

    task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] w, input logic [3:0] c);
        bus.addr[p*XLEN +: XLEN]  = a;
        bus.wdata[p*XLEN +: XLEN] = w;
        bus.ctl[p*CTLW +: CTLW]   = c;
        p_addr[p]  = a;
        p_wdata[p] = w;
        p_ctl[p]   = c;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.ack == '0 && n < 40);
        if (bus.ack == '0) begin
            checks++;
            errors++;
            $display("FAIL ack_wait: no ack within %0d cycles (cycle %0d)", n, cyc);
        end
    endtask

    task automatic expect_grant(input string nm, input int g, input logic [31:0] a);
        int n;
        logic [NPORTS-1:0] oh;
        oh    = '0;
        oh[g] = 1'b1;
        wait_ack(n);
        chk({nm, "_ack"}, 64'(bus.ack), 64'(oh));
        chk({nm, "_addr"}, 64'(bus.mem_addr), 64'(a));
    endtask

    initial begin
        int n;
        int m_last, m_grant, m_due, m_free_at, g;
        bit m_busy, found;
        logic [31:0] m_rdata;
        logic        m_err;
        logic [NPORTS-1:0] exp_ack;

        vecs[0] = '{1, 32'h100, 32'h11, 4'h1, 1, 4'b0010, 32'hDEADBEEF, 1'b0, 2};
        vecs[1] = '{0, 32'h200, 32'h22, 4'h2, 0, 4'b0001, rdfn(32'h200), 1'b0, 1};
        vecs[2] = '{3, 32'h3FC, 32'h33, 4'h3, 7, 4'b1000, rdfn(32'h3FC), 1'b0, 8};
        vecs[3] = '{2, 32'h044, 32'h44, 4'h4, 9, 4'b0100, 32'h0,         1'b1, 8};
        vecs[4] = '{3, 32'h058, 32'h55, 4'h5, 8, 4'b1000, 32'h0,         1'b1, 8};
        vecs[5] = '{2, 32'h0A0, 32'h66, 4'hF, 3, 4'b0100, rdfn(32'h0A0), 1'b0, 4};

        bus.req = '0; bus.addr = '0; bus.wdata = '0; bus.ctl = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        for (int p = 0; p < NPORTS; p++) set_port(p, 32'h0, 32'h0, 4'h0);

        do_reset();
        chk("rst_ack",       64'(bus.ack),       64'(0));
        chk("rst_err",       64'(bus.err),       64'(0));
        chk("rst_rdata",     64'(bus.rdata),     64'(0));
        chk("rst_mem_req",   64'(bus.mem_req),   64'(0));
        chk("rst_mem_addr",  64'(bus.mem_addr),  64'(0));
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
        chk("rst_mem_ctl",   64'(bus.mem_ctl),   64'(0));

        for (int i = 0; i < 6; i++) begin
            next_lat = vecs[i].lat;
            set_port(vecs[i].port, vecs[i].addr, vecs[i].wdata, vecs[i].ctl);
            bus.req[vecs[i].port] = 1'b1;
            tick();
            chk($sformatf("vec%0d_mem_req", i),   64'(bus.mem_req),   64'(1));
            chk($sformatf("vec%0d_mem_addr", i),  64'(bus.mem_addr),  64'(vecs[i].addr));
            chk($sformatf("vec%0d_mem_wdata", i), 64'(bus.mem_wdata), 64'(vecs[i].wdata));
            chk($sformatf("vec%0d_mem_ctl", i),   64'(bus.mem_ctl),   64'(vecs[i].ctl));
            wait_ack(n);
            chk($sformatf("vec%0d_latency", i), 64'(n),          64'(vecs[i].exp_n));
            chk($sformatf("vec%0d_ack", i),     64'(bus.ack),    64'(vecs[i].exp_ack));
            chk($sformatf("vec%0d_rdata", i),   64'(bus.rdata),  64'(vecs[i].exp_rdata));
            chk($sformatf("vec%0d_err", i),     64'(bus.err),    64'(vecs[i].exp_err));
            bus.req[vecs[i].port] = 1'b0;
            tick();
            chk($sformatf("vec%0d_ack_pulse", i), 64'(bus.ack), 64'(0));
            chk($sformatf("vec%0d_err_clear", i), 64'(bus.err), 64'(0));
            tick();
            chk($sformatf("vec%0d_idle", i), 64'(bus.mem_req), 64'(0));
        end

        // Contention: ports 0 and 1 held from reset alternate.
        do_reset();
        next_lat = 0;
        set_port(0, 32'h1000, 32'hA0, 4'h1);
        set_port(1, 32'h2000, 32'hA1, 4'h2);
        bus.req = 4'b0011;
        expect_grant("cont0", 0, 32'h1000);
        expect_grant("cont1", 1, 32'h2000);
        expect_grant("cont2", 0, 32'h1000);
        expect_grant("cont3", 1, 32'h2000);
        bus.req = '0;
        tick(); tick();

        // Fairness: after a grant to port 2, ports 0,2,3 go 3,0,2,3.
        do_reset();
        set_port(2, 32'h3000, 32'hB2, 4'h3);
        bus.req = 4'b0100;
        expect_grant("fair_seed", 2, 32'h3000);
        set_port(0, 32'h1000, 32'hB0, 4'h4);
        set_port(3, 32'h4000, 32'hB3, 4'h5);
        bus.req = 4'b1101;
        expect_grant("fair0", 3, 32'h4000);
        expect_grant("fair1", 0, 32'h1000);
        expect_grant("fair2", 2, 32'h3000);
        expect_grant("fair3", 3, 32'h4000);
        bus.req = '0;
        tick(); tick();

        // Timeout after a successful read, then a stray late mem_ack.
        do_reset();
        next_lat = 0;
        set_port(0, 32'h10, 32'h0, 4'h0);
        bus.req = 4'b0001;
        wait_ack(n);
        chk("to_prior_rdata", 64'(bus.rdata), 64'(rdfn(32'h10)));
        bus.req = '0;
        tick(); tick();
        next_lat = 1000;
        set_port(1, 32'h20, 32'h0, 4'h0);
        bus.req = 4'b0010;
        tick();
        chk("to_mem_req", 64'(bus.mem_req), 64'(1));
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            chk($sformatf("to_wait%0d_ack", k), 64'(bus.ack), 64'(0));
        end
        tick();
        chk("to_ack",   64'(bus.ack),   64'(4'b0010));
        chk("to_err",   64'(bus.err),   64'(1));
        chk("to_rdata", 64'(bus.rdata), 64'(0));
        bus.req       = '0;
        mem_auto      = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h12345678;
        tick();
        bus.mem_ack = 1'b0;
        chk("late_ack_ack", 64'(bus.ack), 64'(0));
        chk("late_ack_err", 64'(bus.err), 64'(0));
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("late_ack_quiet", 64'({bus.ack, bus.mem_req}), 64'(0));
        end
        mem_auto = 1'b1;

        // Reset while BUSY abandons the access; port 0 wins afterwards.
        do_reset();
        next_lat = 1000;
        set_port(3, 32'h30, 32'h0, 4'h0);
        bus.req = 4'b1000;
        tick();
        chk("rb_mem_req", 64'(bus.mem_req), 64'(1));
        tick(); tick(); tick();
        set_port(0, 32'h40, 32'h0, 4'h0);
        bus.req = 4'b1001;
        rst = 1'b1;
        tick();
        chk("rb_mem_req_clr", 64'(bus.mem_req),  64'(0));
        chk("rb_ack_clr",     64'(bus.ack),      64'(0));
        chk("rb_addr_clr",    64'(bus.mem_addr), 64'(0));
        rst      = 1'b0;
        next_lat = 0;
        expect_grant("rb_after", 0, 32'h40);
        bus.req = '0;
        tick(); tick();

        // Held fields: port address changes mid-BUSY must not leak through.
        next_lat = 4;
        set_port(1, 32'h500, 32'h0, 4'h0);
        bus.req = 4'b0010;
        tick();
        chk("hold_addr0", 64'(bus.mem_addr), 64'(32'h500));
        bus.addr[1*XLEN +: XLEN] = 32'hBAD0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_addr_busy", 64'(bus.mem_addr), 64'(32'h500));
            chk("hold_no_ack",    64'(bus.ack),      64'(0));
        end
        wait_ack(n);
        chk("hold_ack",   64'(bus.ack),      64'(4'b0010));
        chk("hold_addr",  64'(bus.mem_addr), 64'(32'h500));
        chk("hold_rdata", 64'(bus.rdata),    64'(rdfn(32'h500)));
        bus.req = '0;
        tick(); tick();

        // Randomized traffic against a transaction-level model.
        do_reset();
        m_last    = NPORTS - 1;
        m_busy    = 1'b0;
        m_grant   = 0;
        m_due     = 0;
        m_free_at = cyc + 1;
        m_rdata   = '0;
        m_err     = 1'b0;
        for (int it = 0; it < 3000; it++) begin
            if (!mem_active) next_lat = $urandom_range(0, 9);
            tick();
            exp_ack = '0;
            if (m_busy && cyc == m_due) begin
                exp_ack[m_grant] = 1'b1;
                m_last    = m_grant;
                m_busy    = 1'b0;
                m_free_at = cyc + 2;
                chk("rnd_rdata", 64'(bus.rdata), 64'(m_rdata));
                chk("rnd_err",   64'(bus.err),   64'(m_err));
            end else if (!m_busy && cyc >= m_free_at && prev_req != '0) begin
                found = 1'b0;
                g     = 0;
                for (int k = 1; k <= NPORTS; k++) begin
                    if (!found && prev_req[(m_last + k) % NPORTS]) begin
                        g     = (m_last + k) % NPORTS;
                        found = 1'b1;
                    end
                end
                m_grant = g;
                m_busy  = 1'b1;
                m_due   = cyc + ((cur_lat < TIMEOUT) ? cur_lat + 1 : TIMEOUT);
                m_err   = (cur_lat >= TIMEOUT);
                m_rdata = m_err ? 32'h0 : rdfn(p_addr[g]);
                chk("rnd_mem_addr",  64'(bus.mem_addr),  64'(p_addr[g]));
                chk("rnd_mem_wdata", 64'(bus.mem_wdata), 64'(p_wdata[g]));
                chk("rnd_mem_ctl",   64'(bus.mem_ctl),   64'(p_ctl[g]));
            end
            chk("rnd_ack",     64'(bus.ack),     64'(exp_ack));
            chk("rnd_mem_req", 64'(bus.mem_req), 64'(m_busy));
            for (int p = 0; p < NPORTS; p++) begin
                if (bus.ack[p]) begin
                    bus.req[p] = 1'b0;
                end else if (!bus.req[p] && $urandom_range(0, 2) == 0) begin
                    set_port(p, $urandom, $urandom, 4'($urandom_range(0, 15)));
                    bus.req[p] = 1'b1;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
